// File: rtl/grant_responder_pkg.sv
// Shared types for the grant responder: service FSM states, the buffered entry
// and one-hot grant decode helpers.
package grant_responder_pkg;

    localparam int GR_N  = 4;
    localparam int GR_DW = 8;
    localparam int GR_IW = $clog2(GR_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        PRESENT = 2'd2
    } svc_state_e;

    typedef struct packed {
        logic [GR_IW-1:0] client;
        logic [GR_DW-1:0] data;
    } gr_entry_t;

    function automatic logic is_onehot(input logic [GR_N-1:0] v);
        return (v != {GR_N{1'b0}}) &&
               ((v & (v - {{(GR_N-1){1'b0}}, 1'b1})) == {GR_N{1'b0}});
    endfunction

    // OR of set-bit positions; exact index only when v is one-hot.
    function automatic logic [GR_IW-1:0] onehot_to_idx(input logic [GR_N-1:0] v);
        logic [GR_IW-1:0] idx;
        idx = {GR_IW{1'b0}};
        for (int i = 0; i < GR_N; i++) begin
            if (v[i]) idx = idx | GR_IW'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/grant_responder_if.sv
// Arbiter-facing request/grant/ready signals plus the serviced-item output port.
interface grant_responder_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic [N-1:0]         grant;
    logic [N*DW-1:0]      wdata;
    logic                 ready;
    logic                 out_valid;
    logic [$clog2(N)-1:0] out_client;
    logic [DW-1:0]        out_data;
    logic                 out_ready;
    logic                 grant_err;

    modport slave (
        input  grant, wdata, out_ready,
        output ready, out_valid, out_client, out_data, grant_err
    );

    modport master (
        output grant, wdata, out_ready,
        input  ready, out_valid, out_client, out_data, grant_err
    );
endinterface

// File: rtl/grant_resp_fifo.sv
// Synchronous FIFO with naturally wrapping pointers; push/pop are gated
// internally against full/empty.
module grant_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    // Next pointer, storage and occupancy
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) rd_ptr_d = rd_ptr_q + 1'b1;
        else          rd_ptr_d = rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {W{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == {(AW+1){1'b0}});
    assign count = count_q;

endmodule

// File: rtl/grant_responder.sv
// Shared-resource side of the round-robin protocol: accepts granted payloads into
// a FIFO, services each for SERVICE_CYCLES, presents them tagged with the client.
// Optional accept/stall counters are built when GRANT_RESP_STATS_EN is defined.
module grant_responder
    import grant_responder_pkg::*;
#(
    parameter int N              = GR_N,
    parameter int DW             = GR_DW,
    parameter int DEPTH          = 4,
    parameter int SERVICE_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    grant_responder_if.slave   bus
`ifdef GRANT_RESP_STATS_EN
    ,
    output logic [15:0]        accept_count,
    output logic [15:0]        stall_count
`endif
);
    localparam int IW    = $clog2(N);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = $bits(gr_entry_t);
    localparam int CNT_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;

    logic            grant_ok_s, grant_multi_s, ready_s, push_s, pop_s;
    logic            full_s, empty_s;
    logic [CW-1:0]   count_s;
    logic [IW-1:0]   grant_idx_s;
    logic [EW-1:0]   head_raw_s;
    gr_entry_t       push_entry_s, head_s;

    svc_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    gr_entry_t       svc_q, svc_d;
    logic            out_valid_q, out_valid_d;
    logic            grant_err_q, grant_err_d;

    // Accept path; ready depends only on the registered occupancy
    always_comb begin
        grant_ok_s          = is_onehot(bus.grant);
        grant_multi_s       = (bus.grant != {N{1'b0}}) && !grant_ok_s;
        grant_idx_s         = onehot_to_idx(bus.grant);
        ready_s             = (count_s != CW'(DEPTH));
        push_s              = ready_s && grant_ok_s && !full_s;
        push_entry_s.client = grant_idx_s;
        push_entry_s.data   = bus.wdata[int'(grant_idx_s)*DW +: DW];
        grant_err_d         = grant_err_q || grant_multi_s;
    end

    grant_resp_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_entry_s),
        .rdata (head_raw_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign head_s = head_raw_s;

    // Service FSM state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            svc_q       <= {EW{1'b0}};
            out_valid_q <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            svc_q       <= svc_d;
            out_valid_q <= out_valid_d;
            grant_err_q <= grant_err_d;
        end
    end

    // Service FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty_s) state_d = SERVICE; else state_d = IDLE;
            SERVICE: if (cnt_q == {CNT_W{1'b0}}) state_d = PRESENT; else state_d = SERVICE;
            PRESENT: if (bus.out_ready) state_d = IDLE; else state_d = PRESENT;
            default: state_d = IDLE;
        endcase
    end

    // Pop, service countdown and output register inputs
    always_comb begin
        pop_s = (state_q == IDLE) && !empty_s;
        cnt_d = cnt_q;
        svc_d = svc_q;
        if (pop_s) begin
            cnt_d = CNT_W'(SERVICE_CYCLES - 1);
            svc_d = head_s;
        end else if ((state_q == SERVICE) && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
        out_valid_d = (state_d == PRESENT);
    end

    assign bus.ready      = ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_client = svc_q.client;
    assign bus.out_data   = svc_q.data;
    assign bus.grant_err  = grant_err_q;

`ifdef GRANT_RESP_STATS_EN
    logic [15:0] acc_cnt_q, acc_cnt_d, stall_cnt_q, stall_cnt_d;

    // Saturating accept and blocked-grant counters
    always_comb begin
        if (push_s && (acc_cnt_q != 16'hFFFF)) acc_cnt_d = acc_cnt_q + 16'd1;
        else                                   acc_cnt_d = acc_cnt_q;
        if ((bus.grant != {N{1'b0}}) && !ready_s && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        else
            stall_cnt_d = stall_cnt_q;
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt_q   <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            acc_cnt_q   <= acc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign accept_count = acc_cnt_q;
    assign stall_count  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_grant_responder.sv
// Self-checking bench for grant_responder: directed scenarios plus randomized
// traffic against a timestamp-based queue model of the responder.
module tb_grant_responder;
    localparam int N = 4, DW = 8, DEPTH = 4, SC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    grant_responder_if #(.N(N), .DW(DW)) bus();
`ifdef GRANT_RESP_STATS_EN
    logic [15:0] accept_count, stall_count;
`endif

    grant_responder #(.N(N), .DW(DW), .DEPTH(DEPTH), .SERVICE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
`ifdef GRANT_RESP_STATS_EN
        , .accept_count (accept_count)
        , .stall_count  (stall_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: waiting queue of client*256+data, one item in service
    // that becomes visible at edge count m_pres_at.
    int mq[$];
    bit m_busy, m_err;
    int m_item, m_pres_at, m_cyc, m_acc, m_stall;

    function automatic bit m_ready();
        return mq.size() != DEPTH;
    endfunction

    function automatic bit m_valid();
        return m_busy && (m_cyc >= m_pres_at);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_err = 0; m_item = 0; m_pres_at = 0;
        m_cyc = 0; m_acc = 0; m_stall = 0;
    endtask

    task automatic model_edge();
        bit rdy, vld;
        int idx;
        rdy = m_ready();
        vld = m_valid();
        if (bus.grant != 4'b0000 && $countones(bus.grant) != 1) m_err = 1;
        if (bus.grant != 4'b0000 && !rdy && m_stall < 65535) m_stall++;
        if (m_busy && vld && bus.out_ready) begin
            m_busy = 0;
        end else if (!m_busy && mq.size() > 0) begin
            m_item = mq.pop_front();
            m_busy = 1;
            m_pres_at = m_cyc + 1 + SC;
        end
        if (rdy && $countones(bus.grant) == 1) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (bus.grant[i]) idx = i;
            mq.push_back(idx * 256 + int'(bus.wdata[idx*DW +: DW]));
            if (m_acc < 65535) m_acc++;
        end
        m_cyc++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.grant = 4'b0000;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        total++; if (bus.ready !== 1'b1)      begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        total++; if (bus.out_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_client !== 2'd0) begin bad++; $display("FAIL reset_client got=%0d exp=0", bus.out_client); end
        total++; if (bus.out_data !== 8'h00)  begin bad++; $display("FAIL reset_data got=%h exp=00", bus.out_data); end
        total++; if (bus.grant_err !== 1'b0)  begin bad++; $display("FAIL reset_err got=%b exp=0", bus.grant_err); end
`ifdef GRANT_RESP_STATS_EN
        total++; if (accept_count !== 16'd0 || stall_count !== 16'd0) begin
            bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", accept_count, stall_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        int first_rise;
        logic [31:0] w;
        w = $urandom;
        w[23:16] = 8'hA5;
        bus.out_ready = 1'b0;
        bus.grant = 4'b0100;
        bus.wdata = w;
        tick();
        bus.grant = 4'b0000;
        first_rise = -1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++; if (bus.out_valid !== m_valid()) begin
                bad++; $display("FAIL latency_valid e=%0d got=%b exp=%b", e, bus.out_valid, m_valid()); end
            if (bus.out_valid === 1'b1 && first_rise < 0) first_rise = e;
        end
        total++; if (first_rise != SC + 1) begin bad++; $display("FAIL latency_edges got=%0d exp=%0d", first_rise, SC + 1); end
        total++; if (bus.out_client !== 2'd2) begin bad++; $display("FAIL latency_client got=%0d exp=2", bus.out_client); end
        total++; if (bus.out_data !== 8'hA5)  begin bad++; $display("FAIL latency_data got=%h exp=a5", bus.out_data); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL latency_leave got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_fill_order();
        logic [7:0] exp_d[$];
        int got_c[$], got_d[$];
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.grant = 4'b0001 << (k % 4);
            bus.wdata = $urandom;
            exp_d.push_back(bus.wdata[(k % 4)*DW +: DW]);
            tick();
            total++; if (bus.ready !== (k != 4)) begin
                bad++; $display("FAIL fill_ready k=%0d got=%b exp=%b", k, bus.ready, (k != 4)); end
        end
        bus.grant = 4'b0000;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 80 && got_c.size() < 5; n++) begin
            if (bus.out_valid === 1'b1) begin
                got_c.push_back(int'(bus.out_client));
                got_d.push_back(int'(bus.out_data));
            end
            tick();
        end
        bus.out_ready = 1'b0;
        total++; if (got_c.size() != 5) begin bad++; $display("FAIL order_count got=%0d exp=5", got_c.size()); end
        for (int i = 0; i < got_c.size(); i++) begin
            total++; if (got_c[i] != i % 4 || got_d[i] != int'(exp_d[i])) begin
                bad++; $display("FAIL order_item i=%0d got=%0d/%h exp=%0d/%h", i, got_c[i], got_d[i], i % 4, exp_d[i]); end
        end
    endtask

    task automatic test_full_pending();
        int n, hs;
        bit accepted;
        bus.out_ready = 1'b0;
        n = 0;
        while (m_ready() && n < 10) begin
            bus.grant = 4'b0001 << (n % 4);
            bus.wdata = $urandom;
            tick();
            n++;
        end
        bus.grant = 4'b0010;
        bus.wdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL full_ready i=%0d got=%b exp=0", i, bus.ready); end
        end
        for (int i = 0; i < 20 && !m_valid(); i++) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            total++; if (bus.ready !== m_ready()) begin
                bad++; $display("FAIL pend_ready i=%0d got=%b exp=%b", i, bus.ready, m_ready()); end
            if (m_ready()) accepted = 1;
            tick();
        end
        bus.grant = 4'b0000;
        total++; if (!accepted || bus.ready !== 1'b0) begin
            bad++; $display("FAIL pend_accept got=%b/%b exp=1/0", accepted, bus.ready); end
        bus.out_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 100 && (m_busy || mq.size() > 0); i++) begin
            if (bus.out_valid === 1'b1) begin
                hs++;
                total++; if (int'(bus.out_client) != (m_item >> 8) || int'(bus.out_data) != (m_item & 255)) begin
                    bad++; $display("FAIL drain_item got=%0d/%h exp=%0d/%h", bus.out_client, bus.out_data, m_item >> 8, m_item & 255); end
            end
            tick();
        end
        bus.out_ready = 1'b0;
        total++; if (hs != 5) begin bad++; $display("FAIL drain_count got=%0d exp=5", hs); end
    endtask

    task automatic test_grant_err();
        logic [7:0] d;
        int seen;
        bus.grant = 4'b0110;
        bus.wdata = $urandom;
        tick();
        bus.grant = 4'b0000;
        total++; if (bus.grant_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", bus.grant_err); end
        total++; if (bus.ready !== 1'b1)     begin bad++; $display("FAIL err_ready got=%b exp=1", bus.ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL err_nopush i=%0d got=%b exp=0", i, bus.out_valid); end
        end
        bus.grant = 4'b0001;
        bus.wdata = $urandom;
        d = bus.wdata[7:0];
        tick();
        bus.grant = 4'b0000;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            total++; if (bus.grant_err !== 1'b1) begin bad++; $display("FAIL err_sticky i=%0d got=%b exp=1", i, bus.grant_err); end
            if (bus.out_valid === 1'b1) begin
                seen++;
                total++; if (bus.out_data !== d || bus.out_client !== 2'd0) begin
                    bad++; $display("FAIL err_legal got=%0d/%h exp=0/%h", bus.out_client, bus.out_data, d); end
            end
            tick();
        end
        bus.out_ready = 1'b0;
        total++; if (seen != 1) begin bad++; $display("FAIL err_seen got=%0d exp=1", seen); end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            total++; if (bus.ready !== m_ready() || bus.out_valid !== m_valid() || bus.grant_err !== m_err) begin
                bad++; $display("FAIL rand_ctl c=%0d got=%b%b%b exp=%b%b%b", c, bus.ready, bus.out_valid, bus.grant_err,
                                m_ready(), m_valid(), m_err); end
            if (m_valid()) begin
                total++; if (int'(bus.out_client) != (m_item >> 8) || int'(bus.out_data) != (m_item & 255)) begin
                    bad++; $display("FAIL rand_item c=%0d got=%0d/%h exp=%0d/%h", c, bus.out_client, bus.out_data, m_item >> 8, m_item & 255); end
            end
`ifdef GRANT_RESP_STATS_EN
            total++; if (int'(accept_count) != m_acc || int'(stall_count) != m_stall) begin
                bad++; $display("FAIL rand_stats c=%0d got=%0d/%0d exp=%0d/%0d", c, accept_count, stall_count, m_acc, m_stall); end
`endif
            r = $urandom_range(0, 9);
            if (r <= 5)      bus.grant = 4'b0001 << $urandom_range(0, 3);
            else if (r <= 8) bus.grant = 4'b0000;
            else             bus.grant = 4'b0011 << $urandom_range(0, 2);
            bus.wdata = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.grant = 4'b0000;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.grant = 4'b0011;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.grant = 4'b0001 << k;
            bus.wdata = $urandom;
            tick();
        end
        bus.grant = 4'b0000;
        total++; if (bus.grant_err !== 1'b1 || !m_busy || m_valid() || mq.size() != 3) begin
            bad++; $display("FAIL mid_pre got=%b/%0d exp=1/3", bus.grant_err, mq.size()); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus.ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.grant_err !== 1'b0) begin
            bad++; $display("FAIL mid_ctl got=%b%b%b exp=100", bus.ready, bus.out_valid, bus.grant_err); end
        total++; if (bus.out_client !== 2'd0 || bus.out_data !== 8'h00) begin
            bad++; $display("FAIL mid_out got=%0d/%h exp=0/00", bus.out_client, bus.out_data); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (bus.ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL mid_after i=%0d got=%b%b exp=10", i, bus.ready, bus.out_valid); end
        end
    endtask

`ifdef GRANT_RESP_STATS_EN
    task automatic test_stats();
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.grant = 4'b0001 << (k % 4);
            bus.wdata = $urandom;
            tick();
        end
        bus.grant = 4'b0000;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10 && bus.ready !== 1'b1; i++) tick();
        bus.grant = 4'b1000;
        bus.wdata = $urandom;
        tick();
        bus.grant = 4'b0000;
        total++; if (accept_count !== 16'd6 || m_acc != 6) begin
            bad++; $display("FAIL stats_accept got=%0d exp=6", accept_count); end
        total++; if (stall_count !== 16'd3 || m_stall != 3) begin
            bad++; $display("FAIL stats_stall got=%0d exp=3", stall_count); end
    endtask
`endif

    initial begin
        bus.grant = 4'b0000;
        bus.wdata = 32'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_fill_order();
        test_full_pending();
        test_grant_err();
        test_random();
        test_reset_mid();
`ifdef GRANT_RESP_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
